// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard consumer: turns load-use, branch-redirect and data-memory wait
// requests into per-stage write enables, bubbles and flushes, plus stall statistics.
module pipe_stall_ctrl #(
  parameter int CNT_W          = 16,
  parameter int MEM_TIMEOUT    = 255,
  parameter int LOAD_STALL_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             mem_wait,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_mem_timeout,
  output logic             err_load_stall
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam int LD_W = $clog2(LOAD_STALL_MAX + 2);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(MEM_TIMEOUT);
  localparam logic [LD_W-1:0] LD_MAX  = LD_W'(LOAD_STALL_MAX);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic [LD_W-1:0] r_ld_cnt, w_ld_cnt_nxt;
  logic            w_freeze;
  logic            w_load_applied;
  logic            w_to_hit;

  assign w_freeze       = dmem_req & ~dmem_ready;
  assign w_load_applied = ~w_freeze & ~branch_taken & load_stall;
  assign mem_wait       = (r_state == MEM_WAIT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = w_freeze ? MEM_WAIT : RUN;
    pc_we         = 1'b0;
    if_id_we      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b0;
    mem_wb_bubble = 1'b1;
    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (!w_freeze) begin
      ex_mem_we     = 1'b1;
      mem_wb_bubble = 1'b0;
      id_ex_we      = 1'b1;
      if (branch_taken) begin
        // Redirect wins over load-use: the stalled instruction is wrong-path anyway.
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_stall) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_we    = 1'b1;
        if_id_we = 1'b1;
      end
    end
  end

  always_comb begin
    w_to_cnt_nxt = '0;
    if (r_state == MEM_WAIT)
      w_to_cnt_nxt = (r_to_cnt == TO_SAT) ? r_to_cnt : r_to_cnt + 1'b1;
    w_ld_cnt_nxt = r_ld_cnt;
    if (w_load_applied)
      w_ld_cnt_nxt = (r_ld_cnt > LD_MAX) ? r_ld_cnt : r_ld_cnt + 1'b1;
    else if (!w_freeze)
      w_ld_cnt_nxt = '0;
  end

  // The timeout flag fires once, on the edge the wait reaches its limit, so a clear
  // during a still-stuck wait stays cleared.
  assign w_to_hit = (r_state == MEM_WAIT) && (r_to_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= RUN;
      r_to_cnt        <= '0;
      r_ld_cnt        <= '0;
      stall_cycles    <= '0;
      err_mem_timeout <= 1'b0;
      err_load_stall  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      r_ld_cnt <= w_ld_cnt_nxt;
      if (cnt_clr) begin
        stall_cycles    <= '0;
        err_mem_timeout <= 1'b0;
        err_load_stall  <= 1'b0;
      end else begin
        if (!pc_we && stall_cycles != '1)
          stall_cycles <= stall_cycles + 1'b1;
        if (w_to_hit)
          err_mem_timeout <= 1'b1;
        if (w_ld_cnt_nxt > LD_MAX)
          err_load_stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 3;
  localparam int LMAX    = 2;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, load_stall, branch_taken, dmem_req, dmem_ready, cnt_clr;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble, mem_wait;
  logic [CNT_W-1:0] stall_cycles;
  logic err_mem_timeout, err_load_stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, kept as plain integers.
  bit m_wait;
  int m_wlen, m_lrun, m_stall;
  bit m_eto, m_els;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT), .LOAD_STALL_MAX(LMAX)) dut (
    .clk(clk), .rst_n(rst_n), .load_stall(load_stall), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
    .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .mem_wb_bubble(mem_wb_bubble),
    .mem_wait(mem_wait), .stall_cycles(stall_cycles),
    .err_mem_timeout(err_mem_timeout), .err_load_stall(err_load_stall)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic rn, input logic ls, input logic br, input logic rq,
                     input logic rd, input logic clr);
    bit frz;
    logic [7:0] e_ctl;
    bit e_pc;
    rst_n = rn; load_stall = ls; branch_taken = br; dmem_req = rq; dmem_ready = rd; cnt_clr = clr;
    if (!rn) begin
      m_wait = 0; m_wlen = 0; m_lrun = 0; m_stall = 0; m_eto = 0; m_els = 0;
    end
    frz = rq && !rd;
    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble, mem_wait}
    if (!rn)       e_ctl = 8'b0010_1010;
    else if (frz)  e_ctl = {7'b0000_001, m_wait};
    else if (br)   e_ctl = {7'b1111_110, m_wait};
    else if (ls)   e_ctl = {7'b0001_110, m_wait};
    else           e_ctl = {7'b1101_010, m_wait};
    e_pc = e_ctl[7];
    @(negedge clk);
    check("ctrl", {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
                   mem_wb_bubble, mem_wait}, e_ctl);
    check("stall_cycles", stall_cycles, m_stall);
    check("errs", {err_mem_timeout, err_load_stall}, {m_eto, m_els});
    @(posedge clk);
    if (rn) begin
      if (clr) m_stall = 0;
      else if (!e_pc && m_stall < SAT) m_stall++;
      if (m_wait) m_wlen++; else m_wlen = 0;
      if (!frz) m_lrun = (ls && !br) ? m_lrun + 1 : 0;
      if (clr) begin
        m_eto = 0; m_els = 0;
      end else begin
        if (m_wait && m_wlen == TIMEOUT) m_eto = 1;
        if (m_lrun > LMAX) m_els = 1;
      end
      m_wait = frz;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    idle(2);

    // Reset in the middle of a memory wait.
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(1);
    check("rst_midwait_state", mem_wait, 1'b0);
    check("rst_midwait_cnt", stall_cycles, 0);
    cyc(1, 0, 0, 0, 0, 1);

    // Single load-use stall, then a three-cycle one.
    cyc(1, 1, 0, 0, 0, 0);
    check("ls1_cnt", stall_cycles, 1);
    check("ls1_err", err_load_stall, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
    check("ls3_err", err_load_stall, 1'b1);
    idle(1);
    cyc(1, 0, 0, 0, 0, 1);

    // Branch beats load-use.
    cyc(1, 1, 1, 0, 0, 0);
    check("br_no_stall", stall_cycles, 0);
    idle(1);

    // Four frozen cycles then release, with a branch pending on release.
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 1, 0);
    check("freeze4_cnt", stall_cycles, 4);
    idle(1);
    cyc(1, 0, 0, 0, 0, 1);

    // Timeout: wait never completes; clear while still stuck; then abort.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 0);
    check("timeout_set", err_mem_timeout, 1'b1);
    cyc(1, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 1, 0, 0);
    check("timeout_clr", err_mem_timeout, 1'b0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(1);

    // Counter saturation.
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 0);
    check("sat", stall_cycles, SAT);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rq, rd;
      rq = ($urandom_range(99) < 40);
      rd = ($urandom_range(99) < 45);
      cyc(($urandom_range(299) != 0), ($urandom_range(99) < 35), ($urandom_range(99) < 20),
          rq, rd, ($urandom_range(99) < 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
